// File: rtl/bitmanip_ror_iter_if.sv
// ---------------------------------------------------------------------------
// bitmanip_ror_iter_if
// Request/response bundle for the iterative rotate-right unit.
//   valid_i / ready_o   : request handshake (operand + rotate amount)
//   data_i, shamt_i     : operand and rotate-right amount
//   valid_o / ready_i   : result handshake
//   result_o            : rotated operand
//   busy_o              : an operation is in flight or waiting to be taken
// slave  : seen from the rotate unit
// master : seen from the requester / consumer
// ---------------------------------------------------------------------------
interface bitmanip_ror_iter_if #(
   parameter int SIZE       = 16,
   parameter int SHAMT_SIZE = $clog2(SIZE)
);
   logic                  valid_i;
   logic                  ready_o;
   logic [SIZE-1:0]       data_i;
   logic [SHAMT_SIZE-1:0] shamt_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [SIZE-1:0]       result_o;
   logic                  busy_o;

   modport slave (
      input  valid_i, data_i, shamt_i, ready_i,
      output ready_o, valid_o, result_o, busy_o
   );

   modport master (
      output valid_i, data_i, shamt_i, ready_i,
      input  ready_o, valid_o, result_o, busy_o
   );
endinterface

// File: rtl/bitmanip_ror_iter.sv
// ---------------------------------------------------------------------------
// bitmanip_ror_iter
// Multi-cycle rotate-right: the operand is rotated right by one bit per clock
// until the requested amount is consumed, then held until the consumer takes
// it. Trades latency for a tiny datapath (one 1-bit rotate + a down counter).
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous, active-high reset
//   io     : bitmanip_ror_iter_if.slave (request/result handshakes, busy_o)
// ---------------------------------------------------------------------------
module bitmanip_ror_iter #(
   parameter int SIZE       = 16,
   parameter int SHAMT_SIZE = $clog2(SIZE)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   bitmanip_ror_iter_if.slave   io
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SIZE-1:0]       r_data;
   logic [SIZE-1:0]       w_data_nxt;
   logic [SHAMT_SIZE-1:0] r_cnt;
   logic [SHAMT_SIZE-1:0] w_cnt_nxt;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         r_data <= w_data_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   // Next state and datapath; everything holds unless a state says otherwise
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (io.valid_i) begin
               w_data_nxt  = io.data_i;
               w_cnt_nxt   = io.shamt_i;
               // A zero amount needs no rotate steps at all
               w_state_nxt = (io.shamt_i == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            w_data_nxt = {r_data[0], r_data[SIZE-1:1]};
            w_cnt_nxt  = r_cnt - 1'b1;
            // BUSY is only entered with a non-zero count, so leaving on 1
            // means the counter bottoms out at 0 and never wraps.
            if (r_cnt == SHAMT_SIZE'(1)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (io.ready_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // All outputs are decoded from registered state only
   assign io.ready_o  = (r_state == S_IDLE);
   assign io.valid_o  = (r_state == S_DONE);
   assign io.busy_o   = (r_state == S_BUSY) || (r_state == S_DONE);
   assign io.result_o = r_data;

endmodule

// File: tb/tb_bitmanip_ror_iter.sv
// ---------------------------------------------------------------------------
// tb_bitmanip_ror_iter
// Directed scenarios plus randomized transactions for bitmanip_ror_iter,
// checked against a rotate reference computed from plain shift arithmetic.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bitmanip_ror_iter;
   localparam int SIZE = 16;
   localparam int SW   = $clog2(SIZE);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bitmanip_ror_iter_if #(.SIZE(SIZE)) bus ();

   bitmanip_ror_iter #(.SIZE(SIZE)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .io    (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: rotate right by s computed at full SIZE width
   function automatic logic [SIZE-1:0] rotr(input logic [SIZE-1:0] d, input int s);
      logic [SIZE-1:0] r;
      r = (d >> s) | (d << (SIZE - s));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for exactly one edge; scramble inputs afterwards so
   // any late sampling of data_i/shamt_i shows up as a wrong result.
   task automatic send(input logic [SIZE-1:0] d, input int s);
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.shamt_i = SW'(s);
      tick();
      bus.valid_i = 1'b0;
      bus.data_i  = SIZE'($urandom);
      bus.shamt_i = SW'($urandom);
   endtask

   // Edges after the accepting edge until valid_o is seen; -1 on timeout
   task automatic wait_valid(output int lat);
      lat = 0;
      while (bus.valid_o !== 1'b1 && lat < 4*SIZE) begin
         tick();
         lat++;
      end
      if (bus.valid_o !== 1'b1) lat = -1;
   endtask

   task automatic take_result();
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_chk++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      n_chk++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      n_chk++; if (bus.result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", bus.result_o); end
      tick(); tick();
      #3 rst = 1'b0;
      tick();
      n_chk++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_flags: ready=%b valid=%b busy=%b want 1/0/0", bus.ready_o, bus.valid_o, bus.busy_o);
      end
   endtask

   task automatic test_shift1();
      int lat;
      send(16'h0001, 1);
      n_chk++; if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
         n_fail++; $display("FAIL shift1_busy: busy=%b valid=%b ready=%b want 1/0/0", bus.busy_o, bus.valid_o, bus.ready_o);
      end
      wait_valid(lat);
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL shift1_latency: got %0d want 1", lat); end
      n_chk++; if (bus.result_o !== 16'h8000) begin n_fail++; $display("FAIL shift1_result: got %h want 8000", bus.result_o); end
      take_result();
      n_chk++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_fail++; $display("FAIL shift1_release: ready=%b valid=%b want 1/0", bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      send(16'h1234, 4);
      wait_valid(lat);
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", lat); end
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (bus.result_o !== 16'h4123 || bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold[%0d]: result=%h ready=%b valid=%b want 4123/0/1", i, bus.result_o, bus.ready_o, bus.valid_o);
         end
         tick();
      end
      take_result();
      n_chk++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: ready=%b want 1", bus.ready_o); end
   endtask

   task automatic test_zero_shift();
      int lat;
      send(16'hABCD, 0);
      wait_valid(lat);
      // Zero amount goes straight to DONE on the accepting edge
      n_chk++; if (lat !== 0) begin n_fail++; $display("FAIL zero_latency: got %0d want 0 extra edges", lat); end
      n_chk++; if (bus.result_o !== 16'hABCD) begin n_fail++; $display("FAIL zero_result: got %h want abcd", bus.result_o); end
      bus.data_i  = 16'h5555;
      bus.shamt_i = SW'(3);
      tick(); tick();
      n_chk++; if (bus.result_o !== 16'hABCD || bus.valid_o !== 1'b1) begin
         n_fail++; $display("FAIL zero_hold: result=%h valid=%b want abcd/1", bus.result_o, bus.valid_o);
      end
      take_result();
   endtask

   task automatic test_back_to_back();
      int lat;
      send(16'h8001, 15);
      wait_valid(lat);
      n_chk++; if (lat !== 15) begin n_fail++; $display("FAIL max_latency: got %0d want 15", lat); end
      n_chk++; if (bus.result_o !== 16'h0003) begin n_fail++; $display("FAIL max_result: got %h want 0003", bus.result_o); end
      // Next request already waiting while the result is being taken:
      // DONE must not accept it in the same edge.
      bus.valid_i = 1'b1;
      bus.data_i  = 16'h00F0;
      bus.shamt_i = SW'(2);
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      n_chk++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_no_accept_in_done: ready=%b valid=%b busy=%b want 1/0/0", bus.ready_o, bus.valid_o, bus.busy_o);
      end
      tick();
      bus.valid_i = 1'b0;
      n_chk++; if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_accept: busy=%b ready=%b want 1/0", bus.busy_o, bus.ready_o);
      end
      wait_valid(lat);
      n_chk++; if (lat !== 2 || bus.result_o !== rotr(16'h00F0, 2)) begin
         n_fail++; $display("FAIL b2b_second: lat=%0d result=%h want 2/%h", lat, bus.result_o, rotr(16'h00F0, 2));
      end
      take_result();
   endtask

   task automatic test_reset_mid();
      int lat;
      send(16'hF000, 8);   // now in the 1st BUSY cycle
      tick(); tick();      // now in the 3rd BUSY cycle
      #3 rst = 1'b1;
      #1;
      n_chk++; if (bus.valid_o !== 1'b0 || bus.result_o !== '0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset_abort: valid=%b result=%h ready=%b busy=%b want 0/0000/1/0",
                            bus.valid_o, bus.result_o, bus.ready_o, bus.busy_o);
      end
      #2 rst = 1'b0;
      tick();
      n_chk++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         n_fail++; $display("FAIL midreset_discard: valid=%b ready=%b want 0/1", bus.valid_o, bus.ready_o);
      end
      send(16'h00FF, 8);
      wait_valid(lat);
      n_chk++; if (lat !== 8 || bus.result_o !== 16'hFF00) begin
         n_fail++; $display("FAIL midreset_next: lat=%0d result=%h want 8/ff00", lat, bus.result_o);
      end
      take_result();
   endtask

   task automatic test_random();
      logic [SIZE-1:0] d;
      logic [SIZE-1:0] exp;
      int s, lat, stall;
      for (int n = 0; n < 3000; n++) begin
         d     = SIZE'($urandom);
         s     = int'($urandom_range(0, SIZE-1));
         exp   = rotr(d, s);
         stall = int'($urandom_range(0, 3));
         n_chk++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", n, bus.ready_o); end
         send(d, s);
         wait_valid(lat);
         n_chk++; if (lat !== s) begin n_fail++; $display("FAIL rnd_latency[%0d]: d=%h s=%0d got %0d want %0d", n, d, s, lat, s); end
         n_chk++; if (bus.result_o !== exp) begin n_fail++; $display("FAIL rnd_result[%0d]: d=%h s=%0d got %h want %h", n, d, s, bus.result_o, exp); end
         for (int i = 0; i < stall; i++) begin
            bus.data_i = SIZE'($urandom);
            tick();
            n_chk++; if (bus.result_o !== exp || bus.valid_o !== 1'b1) begin
               n_fail++; $display("FAIL rnd_stall[%0d]: result=%h valid=%b want %h/1", n, bus.result_o, bus.valid_o, exp);
            end
         end
         take_result();
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.data_i  = '0;
      bus.shamt_i = '0;
      #1;
      test_reset();
      test_shift1();
      test_backpressure();
      test_zero_shift();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
